aes_core_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one AES round datapath (`aes_core_top`-style core) between `NUM_REQ` requesters, such as GCM counter-block encryption and hash-subkey generation. It accepts one request at a time, drives the core's enable/message/key, waits for the core's valid, and returns the cypher block to the requester that issued it through a valid/ready response handshake. It sits between the GCM mode logic and the AES core.

---
 rtl/aes_core_arbiter_pkg.sv | 15 +
 rtl/aes_core_arbiter_if.sv | 39 +++
 rtl/aes_core_arbiter_rr_pick.sv | 28 ++
 rtl/aes_core_arbiter.sv | 172 +++++++++++++++++
 tb/tb_aes_core_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/aes_core_arbiter_pkg.sv
// Shared definitions for the AES core arbiter: FSM state encoding and default widths.
package aes_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } arb_state_e;

  localparam int unsigned DefRndSize    = 128;
  localparam int unsigned DefNumReq     = 2;
  localparam int unsigned DefTimeoutCyc = 32;

endpackage

// File: rtl/aes_core_arbiter_if.sv
// Requester-side and core-side signals of the AES core arbiter; slave = arbiter, master = environment.
interface aes_core_arbiter_if
  import aes_pkg::*;
#(
  parameter int unsigned NUM_REQ  = DefNumReq,
  parameter int unsigned RND_SIZE = DefRndSize
);
  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]          i_req;
  logic [NUM_REQ*RND_SIZE-1:0] i_msg;
  logic [NUM_REQ*RND_SIZE-1:0] i_key;
  logic [NUM_REQ-1:0]          o_gnt;
  logic [NUM_REQ-1:0]          o_rsp_valid;
  logic [NUM_REQ-1:0]          i_rsp_ready;
  logic [RND_SIZE-1:0]         o_rsp_data;
  logic                        o_err;
  logic [IdxW-1:0]             o_err_id;
  logic                        o_busy;
  logic                        o_core_en;
  logic [RND_SIZE-1:0]         o_core_msg;
  logic [RND_SIZE-1:0]         o_core_key;
  logic                        i_core_ready;
  logic                        i_core_valid;
  logic [RND_SIZE-1:0]         i_core_cypher;

  modport slave (
    input  i_req, i_msg, i_key, i_rsp_ready, i_core_ready, i_core_valid, i_core_cypher,
    output o_gnt, o_rsp_valid, o_rsp_data, o_err, o_err_id, o_busy, o_core_en, o_core_msg,
           o_core_key
  );

  modport master (
    output i_req, i_msg, i_key, i_rsp_ready, i_core_ready, i_core_valid, i_core_cypher,
    input  o_gnt, o_rsp_valid, o_rsp_data, o_err, o_err_id, o_busy, o_core_en, o_core_msg,
           o_core_key
  );

endinterface

// File: rtl/aes_core_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_idx_i, searching cyclically.
module aes_rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IdxW   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    last_idx_i,
  output logic               any_o,
  output logic [IdxW-1:0]    win_idx_o
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;

  // Rotating the doubled vector puts the index right after last_idx_i at bit 0.
  always_comb begin
    dbl       = {req_i, req_i};
    rot       = NUM_REQ'(dbl >> (int'(last_idx_i) + 1));
    any_o     = |req_i;
    win_idx_o = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (rot[i]) begin
        win_idx_o = IdxW'((int'(last_idx_i) + 1 + i) % int'(NUM_REQ));
      end
    end
  end

endmodule

// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter/sequencer sharing one AES core between NUM_REQ requesters.
// Optional WAIT timeout enabled by defining AES_ARB_TIMEOUT_EN.
module aes_core_arbiter
  import aes_pkg::*;
#(
  parameter int unsigned NUM_REQ     = DefNumReq,
  parameter int unsigned RND_SIZE    = DefRndSize,
  parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
) (
  input logic               clk,
  input logic               rst,
  aes_core_arbiter_if.slave bus
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  arb_state_e            state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [IdxW-1:0]       last_q, last_d;
  logic [RND_SIZE-1:0]   msg_q, msg_d;
  logic [RND_SIZE-1:0]   key_q, key_d;
  logic [RND_SIZE-1:0]   rsp_data_q, rsp_data_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic                  core_en_q, core_en_d;

  logic                  any;
  logic [IdxW-1:0]       win_idx;
  logic [RND_SIZE-1:0]   msg_sel;
  logic [RND_SIZE-1:0]   key_sel;

`ifdef AES_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [IdxW-1:0]       err_id_q, err_id_d;
`endif

  aes_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i      (bus.i_req),
    .last_idx_i (last_q),
    .any_o      (any),
    .win_idx_o  (win_idx)
  );

  always_comb begin
    msg_sel = '0;
    key_sel = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (win_idx == IdxW'(k)) begin
        msg_sel = bus.i_msg[k*RND_SIZE +: RND_SIZE];
        key_sel = bus.i_key[k*RND_SIZE +: RND_SIZE];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    msg_d       = msg_q;
    key_d       = key_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    gnt_d       = '0;
    core_en_d   = 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = 1'b0;
    err_id_d    = '0;
`endif
    unique case (state_q)
      StIdle: begin
        if (any && bus.i_core_ready) begin
          state_d   = StIssue;
          idx_d     = win_idx;
          msg_d     = msg_sel;
          key_d     = key_sel;
          gnt_d     = NUM_REQ'(1) << win_idx;
          core_en_d = 1'b1;
        end
      end
      StIssue: begin
        state_d = StWait;
`ifdef AES_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StWait: begin
        if (bus.i_core_valid) begin
          state_d     = StResp;
          rsp_data_d  = bus.i_core_cypher;
          rsp_valid_d = NUM_REQ'(1) << idx_q;
        end else begin
`ifdef AES_ARB_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
          // Expiry only without a same-cycle core valid, so valid always wins.
          if (cnt_d == CntW'(TIMEOUT_CYC)) begin
            state_d  = StIdle;
            err_d    = 1'b1;
            err_id_d = idx_q;
            last_d   = idx_q;
          end
`endif
        end
      end
      StResp: begin
        if (bus.i_rsp_ready[idx_q]) begin
          state_d     = StIdle;
          rsp_valid_d = '0;
          last_d      = idx_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      last_q      <= IdxW'(NUM_REQ - 1);
      msg_q       <= '0;
      key_q       <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
      gnt_q       <= '0;
      core_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      msg_q       <= msg_d;
      key_q       <= key_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      gnt_q       <= gnt_d;
      core_en_q   <= core_en_d;
    end
  end

`ifdef AES_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      err_q    <= 1'b0;
      err_id_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      err_id_q <= err_id_d;
    end
  end

  assign bus.o_err    = err_q;
  assign bus.o_err_id = err_id_q;
`else
  assign bus.o_err    = 1'b0;
  assign bus.o_err_id = '0;
`endif

  assign bus.o_gnt       = gnt_q;
  assign bus.o_core_en   = core_en_q;
  assign bus.o_core_msg  = msg_q;
  assign bus.o_core_key  = key_q;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_data  = rsp_data_q;
  assign bus.o_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Randomized self-checking bench for aes_core_arbiter against a transaction-level model.
// Define AES_ARB_TIMEOUT_EN to also exercise the WAIT timeout.
module tb_aes_core_arbiter;
  localparam int unsigned N  = 3;
  localparam int unsigned W  = 128;
  localparam int unsigned TO = 32;

  localparam logic [W-1:0] KatMsg = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [W-1:0] KatKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [W-1:0] KatCyp = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_core_arbiter_if #(.NUM_REQ(N), .RND_SIZE(W)) bus ();

  aes_core_arbiter #(
    .NUM_REQ     (N),
    .RND_SIZE    (W),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int last_idx = N - 1;  // model of the round-robin pointer

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int k);
    logic [N-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic int model_pick(input logic [N-1:0] req);
    for (int i = 1; i <= int'(N); i++) begin
      if (req[(last_idx + i) % N]) return (last_idx + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_quiet(input string tag);
    check_eq({tag, "_gnt"}, W'(bus.o_gnt), '0);
    check_eq({tag, "_en"}, W'(bus.o_core_en), '0);
    check_eq({tag, "_err"}, W'(bus.o_err), '0);
  endtask

  task automatic check_all_zero(input string tag);
    check_quiet(tag);
    check_eq({tag, "_rv"}, W'(bus.o_rsp_valid), '0);
    check_eq({tag, "_rdata"}, bus.o_rsp_data, '0);
    check_eq({tag, "_cmsg"}, bus.o_core_msg, '0);
    check_eq({tag, "_ckey"}, bus.o_core_key, '0);
    check_eq({tag, "_busy"}, W'(bus.o_busy), '0);
    check_eq({tag, "_errid"}, W'(bus.o_err_id), '0);
  endtask

  // Drive one request set at a negedge in IDLE and follow it to completion.
  task automatic do_txn(input logic [N-1:0] req, input int stall, input int lat, input int bp,
                        input bit junk, input bit kat);
    logic [W-1:0] msg [N];
    logic [W-1:0] key [N];
    logic [W-1:0] cy;
    int k;
    k = model_pick(req);
    for (int r = 0; r < int'(N); r++) begin
      msg[r] = rnd128();
      key[r] = rnd128();
    end
    if (kat) begin
      msg[k] = KatMsg;
      key[k] = KatKey;
    end
    for (int r = 0; r < int'(N); r++) begin
      bus.i_msg[r*W +: W] = msg[r];
      bus.i_key[r*W +: W] = key[r];
    end
    bus.i_req        = req;
    bus.i_core_ready = (stall == 0);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); @(negedge clk);
      check_quiet("stall");
      check_eq("stall_busy", W'(bus.o_busy), '0);
      if (s == stall - 1) bus.i_core_ready = 1'b1;
    end
    @(posedge clk); @(negedge clk);
    check_eq("issue_gnt", W'(bus.o_gnt), W'(onehot(k)));
    check_eq("issue_en", W'(bus.o_core_en), 1);
    check_eq("issue_msg", bus.o_core_msg, msg[k]);
    check_eq("issue_key", bus.o_core_key, key[k]);
    check_eq("issue_busy", W'(bus.o_busy), 1);
    bus.i_req         = '0;
    bus.i_msg         = {N{rnd128()}};
    bus.i_key         = {N{rnd128()}};
    bus.i_core_valid  = junk;
    bus.i_core_cypher = rnd128();
    cy = kat ? KatCyp : rnd128();
    for (int w = 1; w <= lat + 1; w++) begin
      @(posedge clk); @(negedge clk);
      check_quiet("wait");
      check_eq("wait_rv", W'(bus.o_rsp_valid), '0);
      check_eq("wait_msg", bus.o_core_msg, msg[k]);
      check_eq("wait_key", bus.o_core_key, key[k]);
      check_eq("wait_busy", W'(bus.o_busy), 1);
      bus.i_core_valid  = (w == lat + 1);
      bus.i_core_cypher = (w == lat + 1) ? cy : rnd128();
    end
    for (int b = 0; b <= bp; b++) begin
      @(posedge clk); @(negedge clk);
      check_quiet("resp");
      check_eq("resp_rv", W'(bus.o_rsp_valid), W'(onehot(k)));
      check_eq("resp_data", bus.o_rsp_data, cy);
      check_eq("resp_busy", W'(bus.o_busy), 1);
      bus.i_core_valid  = junk;
      bus.i_core_cypher = rnd128();
      if (b == bp) begin
        bus.i_rsp_ready = onehot(k);
        bus.i_req       = '0;
      end else begin
        bus.i_rsp_ready = N'($urandom) & ~onehot(k);
        bus.i_req       = N'($urandom);
      end
    end
    @(posedge clk); @(negedge clk);
    bus.i_rsp_ready  = '0;
    bus.i_core_valid = 1'b0;
    check_eq("idle_busy", W'(bus.o_busy), '0);
    check_eq("idle_rv", W'(bus.o_rsp_valid), '0);
    check_quiet("idle");
    last_idx = k;
  endtask

`ifdef AES_ARB_TIMEOUT_EN
  task automatic do_timeout(input logic [N-1:0] req);
    int k;
    k = model_pick(req);
    bus.i_req        = req;
    bus.i_core_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("to_gnt", W'(bus.o_gnt), W'(onehot(k)));
    bus.i_req = '0;
    for (int w = 1; w <= int'(TO); w++) begin
      @(posedge clk); @(negedge clk);
      check_eq("to_wait_err", W'(bus.o_err), '0);
      check_eq("to_wait_busy", W'(bus.o_busy), 1);
    end
    @(posedge clk); @(negedge clk);
    check_eq("to_err", W'(bus.o_err), 1);
    check_eq("to_errid", W'(bus.o_err_id), W'(k));
    check_eq("to_busy", W'(bus.o_busy), '0);
    check_eq("to_rv", W'(bus.o_rsp_valid), '0);
    @(posedge clk); @(negedge clk);
    check_eq("to_err_pulse", W'(bus.o_err), '0);
    last_idx = k;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst               = 1'b1;
    bus.i_req         = '0;
    bus.i_msg         = '0;
    bus.i_key         = '0;
    bus.i_rsp_ready   = '0;
    bus.i_core_ready  = 1'b0;
    bus.i_core_valid  = 1'b0;
    bus.i_core_cypher = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Known-answer block through requester 0.
    do_txn(3'b001, 0, 0, 0, 1'b0, 1'b1);
    // Two requesters contending.
    for (int t = 0; t < 4; t++) do_txn(3'b011, 0, t, 0, 1'b0, 1'b0);
    // Response backpressure and core-not-ready stall.
    do_txn(3'b001, 0, 2, 5, 1'b1, 1'b0);
    do_txn(3'b001, 4, 1, 0, 1'b0, 1'b0);
    // Core valid on the last WAIT cycle before a timeout would fire.
    do_txn(3'b111, 0, int'(TO) - 1, 0, 1'b0, 1'b0);
    for (int t = 0; t < 40; t++) begin
      do_txn(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, 2), $urandom_range(0, 5),
             $urandom_range(0, 3), 1'($urandom), 1'b0);
    end

    // Reset while WAIT, then a late core valid must be ignored.
    bus.i_req        = 3'b100;
    bus.i_core_ready = 1'b1;
    bus.i_msg        = {N{rnd128()}};
    bus.i_key        = {N{rnd128()}};
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.i_req = '0;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check_all_zero("midrst");
    rst               = 1'b0;
    bus.i_core_valid  = 1'b1;
    bus.i_core_cypher = rnd128();
    @(posedge clk); @(negedge clk);
    bus.i_core_valid = 1'b0;
    check_all_zero("postrst");
    last_idx = N - 1;
    do_txn(3'b010, 0, 1, 1, 1'b0, 1'b0);
    do_txn(3'b111, 0, 0, 0, 1'b0, 1'b0);

`ifdef AES_ARB_TIMEOUT_EN
    do_timeout(3'b110);
    do_txn(3'b111, 0, 0, 0, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
